// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants and the {bank, index} register address type for the
// register-file scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBANK  = 2;
    localparam int unsigned NREG   = 32;
    localparam int unsigned NRD    = 3;
    localparam int unsigned SP_IDX = 2;
    localparam logic [XLEN-1:0] SP_INIT = 32'h000f4240;

    localparam int unsigned BW = $clog2(NBANK);
    localparam int unsigned IW = $clog2(NREG);
    localparam int unsigned AW = BW + IW;

    typedef struct packed {
        logic [BW-1:0] bank;
        logic [IW-1:0] idx;
    } reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_busy_table.sv
// Per-register busy bits with set/clear/flush and a running count of busy entries.
module sb_busy_table
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned AW_P = AW
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_set,
    input  logic [AW_P-1:0]       i_set_addr,
    input  logic                  i_clr,
    input  logic [AW_P-1:0]       i_clr_addr,
    output logic [(1<<AW_P)-1:0]  o_busy,
    output logic [AW_P:0]         o_busy_cnt
);

    localparam int unsigned N  = 1 << AW_P;
    localparam int unsigned CW = AW_P + 1;

    logic [N-1:0]  r_busy;
    logic [N-1:0]  w_busy_d;
    logic [CW-1:0] r_cnt;
    logic          w_clr_hit;
    logic          w_set_new;

    // Clear is applied before set so a same-cycle clear+set of one entry nets zero.
    always_comb begin
        w_busy_d  = r_busy;
        w_clr_hit = i_clr && r_busy[i_clr_addr];
        if (w_clr_hit) begin
            w_busy_d[i_clr_addr] = 1'b0;
        end
        w_set_new = i_set && !w_busy_d[i_set_addr];
        if (i_set) begin
            w_busy_d[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_cnt  <= r_cnt + CW'(w_set_new) - CW'(w_clr_hit);
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Banked register file with an issue scoreboard: RAW/WAW interlock, writeback
// bypass into registered operands, flush of outstanding-write tracking.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_iss_valid,
    output logic                      o_iss_ready,
    input  logic [NRD-1:0]            i_rs_en,
    input  reg_addr_t [NRD-1:0]       i_rs,
    input  logic                      i_rd_en,
    input  reg_addr_t                 i_rd,
    input  logic                      i_wb_valid,
    input  reg_addr_t                 i_wb_rd,
    input  logic [XLEN-1:0]           i_wb_data,
    input  logic                      i_flush,
    output logic [NRD-1:0][XLEN-1:0]  o_rdata,
    output logic                      o_rdata_valid,
    output logic [AW:0]               o_busy_cnt,
    output logic [31:0]               o_stall_cnt
);

    localparam int unsigned NADDR = 1 << AW;

    logic [XLEN-1:0]           r_regs [NADDR];
    logic [NRD-1:0][XLEN-1:0]  r_rdata;
    logic                      r_rdata_valid;
    logic [31:0]               r_stall_cnt;

    logic [NADDR-1:0]          w_busy;
    logic [NRD-1:0]            w_src_ok;
    logic                      w_dst_ok;
    logic                      w_accept;
    logic                      w_set;
    logic                      w_wb_we;
    logic [NRD-1:0][XLEN-1:0]  w_rdata_d;

    // Address 0 is hardwired zero: no writes, and therefore no bypass either.
    assign w_wb_we = i_wb_valid && (i_wb_rd != '0);

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_src_ok[i]  = !i_rs_en[i] || !w_busy[i_rs[i]] ||
                           (i_wb_valid && (i_wb_rd == i_rs[i]));
            w_rdata_d[i] = (w_wb_we && (i_wb_rd == i_rs[i])) ? i_wb_data : r_regs[i_rs[i]];
        end
    end

    assign w_dst_ok    = !i_rd_en || !w_busy[i_rd] || (i_wb_valid && (i_wb_rd == i_rd));
    assign o_iss_ready = (&w_src_ok) && w_dst_ok && !i_flush && !i_rst;
    assign w_accept    = i_iss_valid && o_iss_ready;
    assign w_set       = w_accept && i_rd_en && (i_rd != '0);

    sb_busy_table #(
        .AW_P (AW)
    ) u_busy_table (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_set      (w_set),
        .i_set_addr (i_rd),
        .i_clr      (i_wb_valid),
        .i_clr_addr (i_wb_rd),
        .o_busy     (w_busy),
        .o_busy_cnt (o_busy_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int a = 0; a < NADDR; a++) begin
                r_regs[a] <= (a == SP_IDX) ? SP_INIT : '0;
            end
        end else if (w_wb_we) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_rdata_valid <= w_accept;
            if (w_accept) begin
                r_rdata <= w_rdata_d;
            end
            if (i_iss_valid && !o_iss_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a set-based reference model checked every cycle.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      iss_valid;
    logic                      iss_ready;
    logic [NRD-1:0]            rs_en;
    logic [NRD-1:0][AW-1:0]    rs;
    logic                      rd_en;
    logic [AW-1:0]             rd;
    logic                      wb_valid;
    logic [AW-1:0]             wb_rd;
    logic [XLEN-1:0]           wb_data;
    logic                      flush;
    logic [NRD-1:0][XLEN-1:0]  rdata;
    logic                      rdata_valid;
    logic [AW:0]               busy_cnt;
    logic [31:0]               stall_cnt;

    regfile_scoreboard u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_iss_valid   (iss_valid),
        .o_iss_ready   (iss_ready),
        .i_rs_en       (rs_en),
        .i_rs          (rs),
        .i_rd_en       (rd_en),
        .i_rd          (rd),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .i_flush       (flush),
        .o_rdata       (rdata),
        .o_rdata_valid (rdata_valid),
        .o_busy_cnt    (busy_cnt),
        .o_stall_cnt   (stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register values, set of busy addresses, last operands.
    logic [XLEN-1:0] m_regs [64];
    bit              m_busy [int];
    logic [XLEN-1:0] m_rdata [NRD];
    bit              m_rdv;
    int unsigned     m_stall;
    bit              m_init = 1'b0;

    function automatic bit m_ready();
        bit ok;
        ok = !flush && !rst;
        for (int i = 0; i < NRD; i++) begin
            if (rs_en[i] && m_busy.exists(int'(rs[i])) && !(wb_valid && wb_rd == rs[i])) ok = 1'b0;
        end
        if (rd_en && m_busy.exists(int'(rd)) && !(wb_valid && wb_rd == rd)) ok = 1'b0;
        return ok;
    endfunction

    always @(negedge clk) begin
        bit acc;
        if (m_init) begin
            check("iss_ready", {63'd0, iss_ready}, {63'd0, m_ready()});
            for (int i = 0; i < NRD; i++) begin
                check($sformatf("rdata[%0d]", i), 64'(rdata[i]), 64'(m_rdata[i]));
            end
            check("rdata_valid", {63'd0, rdata_valid}, {63'd0, m_rdv});
            check("busy_cnt", 64'(busy_cnt), 64'(m_busy.num()));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        end
        if (rst) begin
            for (int a = 0; a < 64; a++) m_regs[a] = (a == 2) ? 32'h000f4240 : 32'h0;
            for (int i = 0; i < NRD; i++) m_rdata[i] = '0;
            m_busy.delete();
            m_rdv   = 1'b0;
            m_stall = 0;
            m_init  = 1'b1;
        end else if (m_init) begin
            acc = iss_valid && m_ready();
            if (iss_valid && !acc) m_stall++;
            m_rdv = acc;
            if (acc) begin
                for (int i = 0; i < NRD; i++) begin
                    if (rs[i] == 0) m_rdata[i] = '0;
                    else if (wb_valid && wb_rd == rs[i]) m_rdata[i] = wb_data;
                    else m_rdata[i] = m_regs[int'(rs[i])];
                end
            end
            if (wb_valid && wb_rd != 0) m_regs[int'(wb_rd)] = wb_data;
            if (flush) begin
                m_busy.delete();
            end else begin
                if (wb_valid) m_busy.delete(int'(wb_rd));
                if (acc && rd_en && rd != 0) m_busy[int'(rd)] = 1'b1;
            end
        end
    end

    task automatic idle();
        iss_valid = 1'b0; rs_en = '0; rs = '0; rd_en = 1'b0; rd = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("reset busy_cnt", 64'(busy_cnt), 64'd0);
        check("reset stall_cnt", 64'(stall_cnt), 64'd0);
        check("reset rdata_valid", {63'd0, rdata_valid}, 64'd0);
        check("reset rdata0", 64'(rdata[0]), 64'd0);

        // Stack pointer and zero register read after reset
        iss_valid = 1'b1; rs_en = 3'b011; rs[0] = 6'h02; rs[1] = 6'h00;
        #1 check("sp issue ready", {63'd0, iss_ready}, 64'd1);
        step();
        check("sp rdata0", 64'(rdata[0]), 64'h000f4240);
        check("sp rdata1", 64'(rdata[1]), 64'd0);
        check("sp valid", {63'd0, rdata_valid}, 64'd1);
        idle(); step();
        check("hold valid", {63'd0, rdata_valid}, 64'd0);
        check("hold rdata0", 64'(rdata[0]), 64'h000f4240);

        // RAW stall released by same-cycle writeback bypass
        iss_valid = 1'b1; rd_en = 1'b1; rd = 6'h05; step();
        check("raw busy set", 64'(busy_cnt), 64'd1);
        idle(); iss_valid = 1'b1; rs_en = 3'b001; rs[0] = 6'h05;
        #1 check("raw stalled", {63'd0, iss_ready}, 64'd0);
        step(); step();
        check("raw stall_cnt", 64'(stall_cnt), 64'd2);
        wb_valid = 1'b1; wb_rd = 6'h05; wb_data = 32'hDEAD;
        #1 check("raw bypass ready", {63'd0, iss_ready}, 64'd1);
        step();
        check("raw bypass data", 64'(rdata[0]), 64'hDEAD);
        check("raw busy clear", 64'(busy_cnt), 64'd0);

        // WAW on FPR 5
        idle(); iss_valid = 1'b1; rd_en = 1'b1; rd = reg_addr_t'{bank: 1'b1, idx: 5'd5};
        step();
        check("waw first", 64'(busy_cnt), 64'd1);
        #1 check("waw stalled", {63'd0, iss_ready}, 64'd0);
        step();
        check("waw stall_cnt", 64'(stall_cnt), 64'd3);
        wb_valid = 1'b1; wb_rd = 6'h25; wb_data = 32'h5555;
        #1 check("waw wb ready", {63'd0, iss_ready}, 64'd1);
        step();
        check("waw busy kept", 64'(busy_cnt), 64'd1);
        idle(); wb_valid = 1'b1; wb_rd = 6'h25; wb_data = 32'h6666; step();
        check("waw drained", 64'(busy_cnt), 64'd0);

        // Flush with three outstanding writers
        idle(); iss_valid = 1'b1; rd_en = 1'b1;
        rd = 6'h07; step();
        rd = 6'h08; step();
        rd = 6'h28; step();
        check("flush pre cnt", 64'(busy_cnt), 64'd3);
        flush = 1'b1; rd = 6'h09;
        #1 check("flush ready", {63'd0, iss_ready}, 64'd0);
        step();
        check("flush cnt", 64'(busy_cnt), 64'd0);
        check("flush stall_cnt", 64'(stall_cnt), 64'd4);
        idle(); wb_valid = 1'b1; wb_rd = 6'h07; wb_data = 32'h1234; step();
        check("post-flush wb cnt", 64'(busy_cnt), 64'd0);
        idle(); iss_valid = 1'b1; rs_en = 3'b001; rs[0] = 6'h07; step();
        check("post-flush data", 64'(rdata[0]), 64'h1234);

        // Zero register
        idle(); wb_valid = 1'b1; wb_rd = 6'h00; wb_data = 32'hFFFF; step();
        idle(); iss_valid = 1'b1; rs_en = 3'b001; rs[0] = 6'h00; rd_en = 1'b1; rd = 6'h00; step();
        check("zero read", 64'(rdata[0]), 64'd0);
        check("zero not busy", 64'(busy_cnt), 64'd0);
        idle(); iss_valid = 1'b1; rs_en = 3'b001; rs[0] = 6'h00;
        wb_valid = 1'b1; wb_rd = 6'h00; wb_data = 32'hBEEF; step();
        check("zero no bypass", 64'(rdata[0]), 64'd0);

        // rd equal to own source reads pre-write value
        idle(); wb_valid = 1'b1; wb_rd = 6'h0A; wb_data = 32'hAAAA; step();
        idle(); iss_valid = 1'b1; rs_en = 3'b001; rs[0] = 6'h0A; rd_en = 1'b1; rd = 6'h0A; step();
        check("self src data", 64'(rdata[0]), 64'hAAAA);
        check("self busy", 64'(busy_cnt), 64'd1);
        idle(); wb_valid = 1'b1; wb_rd = 6'h0A; wb_data = 32'hBBBB; step();
        check("self drained", 64'(busy_cnt), 64'd0);

        // Reset during a stalled issue
        idle(); iss_valid = 1'b1; rd_en = 1'b1; rd = 6'h11; step();
        rd = 6'h12; step();
        check("rst pre cnt", 64'(busy_cnt), 64'd2);
        idle(); iss_valid = 1'b1; rs_en = 3'b001; rs[0] = 6'h11;
        #1 check("rst pre stall", {63'd0, iss_ready}, 64'd0);
        step();
        check("rst pre stall_cnt", 64'(stall_cnt), 64'd5);
        rst = 1'b1; wb_valid = 1'b1; wb_rd = 6'h11; wb_data = 32'h9999;
        #1 check("rst ready low", {63'd0, iss_ready}, 64'd0);
        step();
        check("rst busy_cnt", 64'(busy_cnt), 64'd0);
        check("rst stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst valid", {63'd0, rdata_valid}, 64'd0);
        check("rst rdata0", 64'(rdata[0]), 64'd0);
        rst = 1'b0; wb_valid = 1'b0;
        #1 check("rst released", {63'd0, iss_ready}, 64'd1);
        step();
        check("rst wb dropped", 64'(rdata[0]), 64'd0);
        check("rst reissue valid", {63'd0, rdata_valid}, 64'd1);

        idle(); step(); step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters: XLEN 32, data width; NBANK 2, register banks (0=GPR, 1=FPR); NREG 32, registers per bank; NRD 3, read ports; SP_IDX 2, bank-0 index with non-zero reset; SP_INIT 32'h000f4240, its reset value.
REQ-002 AW = $clog2(NBANK)+$clog2(NREG) (6 by default); address = {bank, index}.
REQ-003 The block has one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 iss_valid  in  1  decoder presents an instruction.
REQ-007 iss_ready  out  1  instruction accepted this cycle when iss_valid is also high.
REQ-008 rs_en / rs  in  NRD / NRD x AW  per-port source enable and address.
REQ-009 rd_en / rd  in  1 / AW  destination enable and address.
REQ-010 wb_valid / wb_rd / wb_data  in  1 / AW / XLEN  writeback port.
REQ-011 flush  in  1  discard all outstanding-write tracking.
REQ-012 rdata  out  NRD x XLEN  registered operands.
REQ-013 rdata_valid  out  1  pulses for one cycle after an accepted issue.
REQ-014 busy_cnt  out  AW+1  number of registers currently busy.
REQ-015 stall_cnt  out  32  count of cycles with iss_valid=1 and iss_ready=0, wraps at 2^32.

Function
REQ-016 Bank-0 index 0 reads 0, ignores writes, and is never busy.
REQ-017 Each register has a busy bit: set at an accepted issue with rd_en; cleared at a wb_valid matching that address.
REQ-018 A source is ready when rs_en=0, or its busy bit is 0, or wb_valid matches it this cycle.
REQ-019 The destination is WAW-free when rd_en=0, or its busy bit is 0, or wb_valid matches it this cycle.
REQ-020 iss_ready is combinational: all sources ready AND destination WAW-free AND flush=0.
REQ-021 On accept, rdata[i] is loaded at the next edge from wb_data when wb_valid matches rs[i] (bypass), else from the register array; rdata_valid=1.
REQ-022 Without accept, rdata holds its value and rdata_valid=0.
REQ-023 Writeback always writes wb_data to the array, independent of iss_valid, stall or flush.
REQ-024 Simultaneous wb to R and accepted issue with rd=R: array takes wb_data; the busy bit ends set.
REQ-025 Issue with rd equal to one of its own sources is legal; the source reads the pre-write value.
REQ-026 flush: all busy bits clear at the next edge; busy_cnt becomes 0; the writeback that cycle still writes; no accept.
REQ-027 busy_cnt is registered: +1 on a set, -1 on a clear, net 0 when both occur in one cycle; it equals popcount(busy).
REQ-028 A writeback to a non-busy register writes data and leaves busy_cnt unchanged.

Reset
REQ-029 On rst: all registers 0 except bank0[SP_IDX]=SP_INIT; all busy bits 0; rdata 0; rdata_valid 0; busy_cnt 0; stall_cnt 0.
REQ-030 rst overrides a writeback, issue or flush in the same cycle; iss_ready=0 while rst=1.

Structure
REQ-031 The shared package holds XLEN, NBANK, NREG, SP_IDX, SP_INIT defaults and a typedef for the {bank, index} register address.
REQ-032 One sub-module, sb_busy_table: busy bits, set/clear/flush logic and busy_cnt; the data array and bypass stay in the top.

Verification
REQ-033 After reset, issue rs={0x02,0x00,-}: rdata={0x000f4240,0}, rdata_valid=1 one cycle later.
REQ-034 Issue rd=0x05; next cycle issue rs0=0x05 -> iss_ready=0 and stall_cnt increments each cycle; wb 0x05=0xDEAD same cycle as retry -> accept, rdata[0]=0xDEAD (bypass), busy_cnt 1->0.
REQ-035 Issue rd=0x25 (FPR 5) while busy, second writer rd=0x25 -> stalled (WAW) until wb 0x25; same-cycle wb plus issue leaves busy set, busy_cnt=1.
REQ-036 Three outstanding writers (busy_cnt=3), assert flush -> iss_ready=0 that cycle, busy_cnt=0 next cycle, later wb 0x07=0x1234 still updates the array.
REQ-037 wb 0x00=0xFFFF then read 0x00 -> 0; rd_en with rd=0x00 never sets busy.
REQ-038 Assert rst during a stalled issue with busy_cnt=2 -> all outputs at reset values next cycle; the stall is released.
